// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: opcode, ALU/compare op codes, instruction
// formats and the decoded control word stored in every queue entry.
package decode_queue_pkg;

    // RV32 base opcodes accepted by the decoder
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    // ALU operation: {funct7[5], funct3} for integer ops. Mul/div ops reuse
    // codes 0..7 and are told apart by the muldiv flag.
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_OR   = 4'b0110;
    localparam alu_op_t ALU_AND  = 4'b0111;
    localparam alu_op_t ALU_SUB  = 4'b1000;
    localparam alu_op_t ALU_SRA  = 4'b1101;
    localparam alu_op_t ALU_MUL    = 4'b0000;
    localparam alu_op_t ALU_MULH   = 4'b0001;
    localparam alu_op_t ALU_MULHSU = 4'b0010;
    localparam alu_op_t ALU_MULHU  = 4'b0011;
    localparam alu_op_t ALU_DIV    = 4'b0100;
    localparam alu_op_t ALU_DIVU   = 4'b0101;
    localparam alu_op_t ALU_REM    = 4'b0110;
    localparam alu_op_t ALU_REMU   = 4'b0111;

    // Compare op: branch funct3 encoding, reused for SLT/SLTU
    typedef logic [2:0] cmp_op_t;
    localparam cmp_op_t CMP_EQ  = 3'b000;
    localparam cmp_op_t CMP_NE  = 3'b001;
    localparam cmp_op_t CMP_LT  = 3'b100;
    localparam cmp_op_t CMP_GE  = 3'b101;
    localparam cmp_op_t CMP_LTU = 3'b110;
    localparam cmp_op_t CMP_GEU = 3'b111;

    // Instruction format; R is zero so an all-zero control word is idle
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } inst_format_t;

    // funct3 / funct7 values the decoder keys on
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Decoded control word kept per queue entry
    typedef struct packed {
        inst_format_t format;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         branch;
        logic         jump;
        logic         compare;
        logic         cmp_imm;
        cmp_op_t      cmp_op;
        logic         alu_imm;
        logic         alu_pc;
        alu_op_t      alu_op;
        logic         mem_read;
        logic         mem_write;
        logic [1:0]   mem_size;
        logic         mem_unsigned;
        logic         muldiv;
        logic         illegal;
    } decode_ctrl_t;

    // Map an M-extension funct3 onto its ALU op code
    function automatic alu_op_t muldiv_alu_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            F3_MUL:    op = ALU_MUL;
            F3_MULH:   op = ALU_MULH;
            F3_MULHSU: op = ALU_MULHSU;
            F3_MULHU:  op = ALU_MULHU;
            F3_DIV:    op = ALU_DIV;
            F3_DIVU:   op = ALU_DIVU;
            F3_REM:    op = ALU_REM;
            default:   op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Circular-buffer FIFO holding pre-decoded entries. The head entry is read
// straight from the storage array so a word written in one cycle is visible
// at the head the next cycle. Pushes when full and pops when empty are ignored.
module decode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             push_en, pop_en;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];

    // Next pointers/occupancy; pointers wrap naturally since DEPTH is 2^AW
    always_comb begin
        wr_ptr_next = wr_ptr_reg + AW'(push_en);
        rd_ptr_next = rd_ptr_reg + AW'(pop_en);
        count_next  = count_reg + CW'(push_en) - CW'(pop_en);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    // Pointer and occupancy registers; reset beats flush, push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage; contents are left alone by reset
    always_ff @(posedge clk) begin
        if (push_en && !flush && !rst) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: decodes each fetched RV32 word on the way in and buffers
// {pc, decoded control} in a small FIFO. in_ready/out_valid come from
// registered occupancy only.
// Optional feature: define RV32M_EN to decode the M extension (mul/div);
// without it those encodings are flagged illegal.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output decode_ctrl_t             out_ctrl,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ENTRY_W = XLEN + $bits(decode_ctrl_t);

    decode_ctrl_t       dec_ctrl;
    logic [ENTRY_W-1:0] head_entry;
    logic [XLEN-1:0]    head_pc;
    decode_ctrl_t       head_ctrl;
    logic               fifo_full, fifo_empty;

    // Combinational RV32 decode of the offered word
    always_comb begin
        opcode_t    opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       legal;

        opc   = opcode_t'(in_instr[6:0]);
        f3    = in_instr[14:12];
        f7    = in_instr[31:25];
        legal = 1'b1;

        dec_ctrl        = '0;
        dec_ctrl.rs1    = in_instr[19:15];
        dec_ctrl.rs2    = in_instr[24:20];
        dec_ctrl.rd     = in_instr[11:7];
        dec_ctrl.cmp_op = f3;

        case (opc)
            OPC_OP: begin
                dec_ctrl.format = FMT_R;
                dec_ctrl.alu_op = {f7[5], f3};
                if (f7 == F7_MULDIV) begin
`ifdef RV32M_EN
                    dec_ctrl.muldiv = 1'b1;
                    dec_ctrl.alu_op = muldiv_alu_op(f3);
`else
                    legal = 1'b0;
`endif
                end else if (f3 == F3_SLT) begin
                    dec_ctrl.compare = 1'b1;
                    dec_ctrl.cmp_op  = CMP_LT;
                end else if (f3 == F3_SLTU) begin
                    dec_ctrl.compare = 1'b1;
                    dec_ctrl.cmp_op  = CMP_LTU;
                end
            end
            OPC_OP_IMM: begin
                dec_ctrl.format  = FMT_I;
                dec_ctrl.alu_imm = 1'b1;
                dec_ctrl.cmp_imm = 1'b1;
                // Only SRAI keeps funct7[5]; elsewhere those bits are immediate
                dec_ctrl.alu_op  = {f7[5] & (f3 == F3_SR), f3};
                if (f3 == F3_SLT) begin
                    dec_ctrl.compare = 1'b1;
                    dec_ctrl.cmp_op  = CMP_LT;
                end else if (f3 == F3_SLTU) begin
                    dec_ctrl.compare = 1'b1;
                    dec_ctrl.cmp_op  = CMP_LTU;
                end
            end
            OPC_LOAD: begin
                dec_ctrl.format       = FMT_I;
                dec_ctrl.alu_imm      = 1'b1;
                dec_ctrl.mem_read     = 1'b1;
                dec_ctrl.mem_size     = f3[1:0];
                dec_ctrl.mem_unsigned = f3[2];
            end
            OPC_STORE: begin
                dec_ctrl.format    = FMT_S;
                dec_ctrl.alu_imm   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.mem_size  = f3[1:0];
                dec_ctrl.rd        = '0;
            end
            OPC_BRANCH: begin
                dec_ctrl.format  = FMT_B;
                dec_ctrl.branch  = 1'b1;
                dec_ctrl.alu_imm = 1'b1;
                dec_ctrl.alu_pc  = 1'b1;
                dec_ctrl.rd      = '0;
            end
            OPC_LUI: begin
                dec_ctrl.format  = FMT_U;
                dec_ctrl.alu_imm = 1'b1;
                dec_ctrl.rs1     = '0;
            end
            OPC_AUIPC: begin
                dec_ctrl.format  = FMT_U;
                dec_ctrl.alu_imm = 1'b1;
                dec_ctrl.alu_pc  = 1'b1;
            end
            OPC_JAL: begin
                dec_ctrl.format  = FMT_J;
                dec_ctrl.jump    = 1'b1;
                dec_ctrl.alu_imm = 1'b1;
                dec_ctrl.alu_pc  = 1'b1;
            end
            OPC_JALR: begin
                dec_ctrl.format  = FMT_I;
                dec_ctrl.jump    = 1'b1;
                dec_ctrl.alu_imm = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words still travel down the queue, carrying only the flag
        if (!legal) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
        end
    end

    decode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (in_valid),
        .pop   (out_ready),
        .wdata ({in_pc, dec_ctrl}),
        .rdata (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_pc, head_ctrl} = head_entry;

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    // Present zeros while empty so stale storage never leaks out
    assign out_pc    = out_valid ? head_pc : '0;
    assign out_ctrl  = out_valid ? head_ctrl : '0;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: a queue-based reference model with its
// own decoder, compared every cycle, plus directed literal checks.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [31:0]            in_instr = '0;
    logic [XLEN-1:0]        in_pc = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [XLEN-1:0]        out_pc;
    decode_ctrl_t           out_ctrl;
    logic [$clog2(DEPTH):0] count;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en = 1'b0;

    typedef struct {
        logic [31:0]  pc;
        decode_ctrl_t ctrl;
    } ref_t;
    ref_t mq[$];

    decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder written from the instruction-set rules
    function automatic decode_ctrl_t ref_decode(input logic [31:0] w);
        decode_ctrl_t c;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit legal, mext, alu_reg_or_imm;
        c  = '0;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        mext  = (op == 7'h33) && (f7 == 7'h01);
        legal = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
`ifndef RV32M_EN
        if (mext) legal = 1'b0;
`endif
        if (!legal) begin
            c.illegal = 1'b1;
            return c;
        end
        c.rs1 = (op == 7'h37) ? 5'd0 : w[19:15];
        c.rs2 = w[24:20];
        c.rd  = (op == 7'h23 || op == 7'h63) ? 5'd0 : w[11:7];
        if (op == 7'h33)                                  c.format = FMT_R;
        else if (op inside {7'h13, 7'h03, 7'h67})         c.format = FMT_I;
        else if (op == 7'h23)                             c.format = FMT_S;
        else if (op == 7'h63)                             c.format = FMT_B;
        else if (op inside {7'h37, 7'h17})                c.format = FMT_U;
        else                                              c.format = FMT_J;
        c.branch       = (op == 7'h63);
        c.jump         = (op == 7'h6f) || (op == 7'h67);
        c.mem_read     = (op == 7'h03);
        c.mem_write    = (op == 7'h23);
        c.mem_size     = (op == 7'h03 || op == 7'h23) ? f3[1:0] : 2'd0;
        c.mem_unsigned = (op == 7'h03) && f3[2];
        c.alu_imm      = (op != 7'h33);
        c.alu_pc       = op inside {7'h63, 7'h17, 7'h6f};
        c.cmp_imm      = (op == 7'h13);
        if (mext) begin
            c.muldiv = 1'b1;
            c.alu_op = {1'b0, f3};
        end else if (op == 7'h33) begin
            c.alu_op = {f7[5], f3};
        end else if (op == 7'h13) begin
            c.alu_op = {(f7[5] && f3 == 3'd5), f3};
        end
        alu_reg_or_imm = ((op == 7'h33) && !mext) || (op == 7'h13);
        c.cmp_op = f3;
        if (alu_reg_or_imm && f3 == 3'd2) begin
            c.compare = 1'b1;
            c.cmp_op  = 3'b100;
        end else if (alu_reg_or_imm && f3 == 3'd3) begin
            c.compare = 1'b1;
            c.cmp_op  = 3'b110;
        end
        return c;
    endfunction

    // Reference model update on each rising edge
    always @(posedge clk) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            bit do_pop, do_push;
            ref_t e;
            do_pop  = (mq.size() != 0) && out_ready;
            do_push = in_valid && (mq.size() < DEPTH);
            if (do_pop) begin
                $display("pop  pc=%h ctrl=%h", mq[0].pc, mq[0].ctrl);
                void'(mq.pop_front());
            end
            if (do_push) begin
                e.pc   = in_pc;
                e.ctrl = ref_decode(in_instr);
                $display("push pc=%h instr=%h", in_pc, in_instr);
                mq.push_back(e);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            sz = mq.size();
            check("count", 64'(count), 64'(sz));
            check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
            check("out_valid", 64'(out_valid), 64'(sz != 0));
            if (sz != 0) begin
                check("out_pc", 64'(out_pc), 64'(mq[0].pc));
                check("out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
            end else begin
                check("out_ctrl_idle", 64'(out_ctrl), 64'd0);
            end
        end
    end

    // One clock cycle of stimulus: drive at negedge, return at the next negedge
    task automatic cyc(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [9];
        logic [6:0]  op;
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
        r = $urandom();
        k = $urandom_range(0, 9);
        if (k == 9) begin
            op = r[6:0];
            if (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67})
                op = 7'h7f;
        end else begin
            op = ops[k];
        end
        if (op == 7'h33) begin
            case ($urandom_range(0, 2))
                0:       r[31:25] = 7'h00;
                1:       r[31:25] = 7'h20;
                default: r[31:25] = 7'h01;
            endcase
        end
        return {r[31:7], op};
    endfunction

    initial begin
        logic [31:0] rpc;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);

        // addi x1, x0, 5 at 0x100 into an empty queue
        cyc(1, 32'h00500093, 32'h100, 0, 0);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_rd", 64'(out_ctrl.rd), 64'd1);
        check("addi_rs1", 64'(out_ctrl.rs1), 64'd0);
        check("addi_alu_imm", 64'(out_ctrl.alu_imm), 64'd1);
        check("addi_format", 64'(out_ctrl.format), 64'(FMT_I));
        check("addi_pc", 64'(out_pc), 64'h100);
        cyc(0, 0, 0, 0, 1);
        check("flush1_count", 64'(count), 64'd0);

        // Fill to DEPTH, then a fifth word must be refused
        for (int i = 0; i < 4; i++) cyc(1, 32'h00000013, 32'h200 + 32'(4 * i), 0, 0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);
        cyc(1, 32'h00100093, 32'h300, 0, 0);
        check("fifth_count", 64'(count), 64'd4);
        check("fifth_head", 64'(out_pc), 64'h200);

        // Full queue with push and pop offered together: only the pop happens
        in_valid = 1; in_instr = 32'h00200093; in_pc = 32'h400; out_ready = 1; flush = 0;
        check("fullpp_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("fullpp_count", 64'(count), 64'd3);
        check("fullpp_head", 64'(out_pc), 64'h204);
        cyc(1, 32'h00200093, 32'h400, 0, 0);
        check("refill_count", 64'(count), 64'd4);

        // count=3, flush with a word offered: everything dropped
        cyc(0, 0, 0, 1, 0);
        check("pre_flush_count", 64'(count), 64'd3);
        cyc(1, 32'h00700093, 32'h500, 1, 1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        cyc(1, 32'h00100093, 32'h600, 0, 0);
        check("post_flush_head", 64'(out_pc), 64'h600);
        check("post_flush_count", 64'(count), 64'd1);
        cyc(0, 0, 0, 1, 0);

        // mul x0, x1, x2
        cyc(1, 32'h02208033, 32'h700, 0, 0);
`ifdef RV32M_EN
        check("mul_muldiv", 64'(out_ctrl.muldiv), 64'd1);
        check("mul_illegal", 64'(out_ctrl.illegal), 64'd0);
        check("mul_rs1", 64'(out_ctrl.rs1), 64'd1);
        check("mul_rs2", 64'(out_ctrl.rs2), 64'd2);
`else
        check("mul_illegal", 64'(out_ctrl.illegal), 64'd1);
        check("mul_muldiv", 64'(out_ctrl.muldiv), 64'd0);
`endif
        cyc(0, 0, 0, 1, 0);

        // All-ones word is illegal but still queued
        cyc(1, 32'hFFFFFFFF, 32'h800, 0, 0);
        check("ones_valid", 64'(out_valid), 64'd1);
        check("ones_illegal", 64'(out_ctrl.illegal), 64'd1);
        check("ones_mem_write", 64'(out_ctrl.mem_write), 64'd0);
        check("ones_jump", 64'(out_ctrl.jump), 64'd0);
        cyc(0, 0, 0, 1, 0);

        // Random push/pop traffic with pointer wrap and occasional flush
        for (int i = 0; i < 300; i++) begin
            rpc = $urandom();
            rpc[1:0] = 2'b00;
            cyc($urandom_range(0, 3) != 0, rand_instr(), rpc,
                $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end

        // Drain
        for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 0, 1, 0);
        check("drain_count", 64'(count), 64'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
